// File: rtl/gate_op_pkg.sv
// Shared opcode and FSM state encodings for the gate-op arbiter slice.
package gate_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/logic_gate_unit.sv
// Combinational WIDTH-bit bitwise gate: AND, OR, XOR or NAND selected by op.
module logic_gate_unit
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one registered gate unit between N_REQ requesters.
// Handshake: req is a level; a one-cycle gnt pulse means op/a/b were captured
// on that edge, and res_valid pulses exactly one cycle later with res_id/res_data.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a,
    input  logic [WIDTH*N_REQ-1:0] b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic [WIDTH-1:0]       res_data,
    output logic                   dbg_state
);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             res_valid_q, res_valid_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   pick;
    int               pick_i;
    logic [WIDTH-1:0] gate_y;

    // First set request strictly after ptr, wrapping modulo N_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] g;
        logic           found;
        int             idx;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && r[idx]) begin
                g     = IDW'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    assign pick   = rr_pick(req, rr_ptr_q);
    assign pick_i = int'(pick);

    logic_gate_unit #(.WIDTH(WIDTH)) u_gate (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (gate_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            rr_ptr_q    <= IDW'(N_REQ - 1);
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|req) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // res_data/res_id hold their last value; only the valid and grant pulses clear.
    always_comb begin
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                    id_d     = pick;
                    rr_ptr_d = pick;
                    op_d     = op[2*pick_i +: 2];
                    a_d      = a[pick_i*WIDTH +: WIDTH];
                    b_d      = b[pick_i*WIDTH +: WIDTH];
                end
            end
            ST_EXEC: begin
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                res_data_d  = gate_y;
            end
            default: ;
        endcase
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed bench for gate_op_arbiter: grant timing, opcodes, fairness, capture, reset.
module tb_gate_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  res_data;
  logic        dbg_state;

  int total = 0;
  int bad = 0;

  gate_op_arbiter #(.N_REQ(4), .WIDTH(8), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one active edge, then park on the falling edge for driving and sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; op = '0; a = '0; b = '0;
    @(posedge clk);
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", res_id); end
    total++; if (res_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", res_data); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", dbg_state); end
  endtask

  task automatic test_first_grant();
    rst_n = 1'b1;
    req = 4'b0001; op[1:0] = 2'b00; a[7:0] = 8'hF0; b[7:0] = 8'h3C;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_gnt: got %b want 0001", gnt); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL first_valid_early: got %b want 0", res_valid); end
    req = 4'b0000;
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", res_valid); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL first_id: got %0d want 0", res_id); end
    total++; if (res_data !== 8'h30) begin bad++; $display("FAIL first_data: got %h want 30", res_data); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL first_gnt_drop: got %b want 0000", gnt); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL first_valid_pulse: got %b want 0", res_valid); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL first_idle_gnt: got %b want 0000", gnt); end
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_res [4] = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};
    a[15:8] = 8'hAA; b[15:8] = 8'h0F;
    req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      op[3:2] = 2'(k);
      step();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ops_gnt[%0d]: got %b want 0010", k, gnt); end
      if (k == 3) req = 4'b0000;
      step();
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ops_valid[%0d]: got %b want 1", k, res_valid); end
      total++; if (res_id !== 2'd1) begin bad++; $display("FAIL ops_id[%0d]: got %0d want 1", k, res_id); end
      total++; if (res_data !== exp_res[k]) begin bad++; $display("FAIL ops_data[%0d]: got %h want %h", k, res_data, exp_res[k]); end
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ops_gnt_low[%0d]: got %b want 0000", k, gnt); end
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1;
    op = 8'h55;
    b = '0;
    for (int i = 0; i < 4; i++) a[i*8 +: 8] = 8'(i + 1);
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      eg = 4'b0001 << (n % 4);
      step();
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, gnt, eg); end
      if (n == 7) req = 4'b0000;
      step();
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", n, res_valid); end
      total++; if (res_id !== 2'(n % 4)) begin bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", n, res_id, n % 4); end
      total++; if (res_data !== 8'(n % 4 + 1)) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", n, res_data, 8'(n % 4 + 1)); end
    end
    step();
  endtask

  task automatic test_capture();
    a[23:16] = 8'h5A; b[23:16] = 8'hFF; op[5:4] = 2'b00;
    req = 4'b0100;
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL cap_gnt: got %b want 0100", gnt); end
    a[23:16] = 8'h00; op[5:4] = 2'b01; req = 4'b0000;
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL cap_valid: got %b want 1", res_valid); end
    total++; if (res_id !== 2'd2) begin bad++; $display("FAIL cap_id: got %0d want 2", res_id); end
    total++; if (res_data !== 8'h5A) begin bad++; $display("FAIL cap_data: got %h want 5a", res_data); end
    step();
  endtask

  task automatic test_reset_in_exec();
    a[15:8] = 8'h33; b[15:8] = 8'h33; op[3:2] = 2'b01;
    req = 4'b0010;
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rexec_gnt: got %b want 0010", gnt); end
    total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL rexec_state_exec: got %b want 1", dbg_state); end
    rst_n = 1'b0; req = 4'b0000;
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rexec_valid: got %b want 0", res_valid); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rexec_gnt_zero: got %b want 0000", gnt); end
    total++; if (res_data !== 8'h00) begin bad++; $display("FAIL rexec_data: got %h want 00", res_data); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL rexec_id: got %0d want 0", res_id); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL rexec_state: got %b want 0", dbg_state); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rexec_valid_late: got %b want 0", res_valid); end
    rst_n = 1'b1;
    a[23:16] = 8'h5A; b[23:16] = 8'hFF; op[5:4] = 2'b00;
    req = 4'b0100;
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rexec_first_gnt: got %b want 0100", gnt); end
    req = 4'b0000;
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL rexec_res_valid: got %b want 1", res_valid); end
    total++; if (res_id !== 2'd2) begin bad++; $display("FAIL rexec_res_id: got %0d want 2", res_id); end
    total++; if (res_data !== 8'h5A) begin bad++; $display("FAIL rexec_res_data: got %h want 5a", res_data); end
    step();
  endtask

  task automatic test_sole_requester();
    logic [3:0] eg;
    logic       ev;
    a[31:24] = 8'hFF; b[31:24] = 8'h0F; op[7:6] = 2'b11;
    req = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      eg = (c % 2 == 0) ? 4'b1000 : 4'b0000;
      ev = (c % 2 == 1);
      step();
      total++; if (gnt !== eg) begin bad++; $display("FAIL sole_gnt[%0d]: got %b want %b", c, gnt, eg); end
      total++; if (res_valid !== ev) begin bad++; $display("FAIL sole_valid[%0d]: got %b want %b", c, res_valid, ev); end
      if (ev) begin
        total++; if (res_data !== 8'hF0) begin bad++; $display("FAIL sole_data[%0d]: got %h want f0", c, res_data); end
        total++; if (res_id !== 2'd3) begin bad++; $display("FAIL sole_id[%0d]: got %0d want 3", c, res_id); end
      end
    end
    req = 4'b0000;
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL sole_no_gnt: got %b want 0000", gnt); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL sole_no_valid: got %b want 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_all_ops();
    test_round_robin();
    test_capture();
    test_reset_in_exec();
    test_sole_requester();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
